// File: rtl/spi_slave_fsm_if.sv
// Bus bundle between the SPI slave front end, the SPI master pins and the
// memory block. The slave modport is the view seen by spi_slave_fsm. The
// master modport is the view seen by whatever drives the pins and the
// memory side.
interface spi_slave_fsm_if #(
    parameter int ADDR_SIZE = 8
);
    logic                   SS_n;
    logic                   MOSI;
    logic                   MISO;
    logic [ADDR_SIZE+1:0]   rx_data;
    logic                   rx_valid;
    logic [ADDR_SIZE-1:0]   tx_data;
    logic                   tx_valid;
    logic                   cmd_err;

    modport slave (
        input  SS_n,
        input  MOSI,
        input  tx_data,
        input  tx_valid,
        output MISO,
        output rx_data,
        output rx_valid,
        output cmd_err
    );

    modport master (
        output SS_n,
        output MOSI,
        output tx_data,
        output tx_valid,
        input  MISO,
        input  rx_data,
        input  rx_valid,
        input  cmd_err
    );
endinterface

// File: rtl/spi_slave_fsm.sv
// SPI slave front end: deserialises MOSI frames into command words for the
// on-chip memory and serialises read data back on MISO.
//
// The serial bit clock is clk itself. Reset is synchronous and active-low.
//
// Optional build macro SPI_CMD_CHECK_EN: when defined, the two code bits of
// each completed word are checked against the state that received it. A
// mismatching word is dropped and flagged with a one-cycle cmd_err pulse.
// When undefined, words are forwarded verbatim and cmd_err is tied low.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no frame; waits for SS_n low
// CHK_CMD   | samples word bit 9 and picks the word type
// WRITE     | receives bits 8..0 of a write-address/data word
// READ_ADD  | receives bits 8..0 of a read-address word
// READ_DATA | receives a read-data word, waits for tx_valid, shifts MISO
module spi_slave_fsm #(
    parameter int ADDR_SIZE = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_slave_fsm_if.slave bus
);

    localparam int W  = ADDR_SIZE + 2;
    localparam int CW = $clog2(W);
    localparam int TW = $clog2(ADDR_SIZE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          bit_cnt, bit_cnt_nxt;
    logic [W-2:0]           rx_shift, rx_shift_nxt;
    logic [W-1:0]           rx_data_q, rx_data_nxt;
    logic                   rx_valid_q, rx_valid_nxt;
    logic                   miso_q, miso_nxt;
    logic                   rd_addr_flag, rd_addr_flag_nxt;
    logic                   word_done, word_done_nxt;
    logic                   tx_wait, tx_wait_nxt;
    logic                   tx_active, tx_active_nxt;
    logic [ADDR_SIZE-2:0]   tx_shift, tx_shift_nxt;
    logic [TW-1:0]          tx_cnt, tx_cnt_nxt;
    logic [W-1:0]           word;
    logic                   word_ok;
`ifdef SPI_CMD_CHECK_EN
    logic                   cmd_err_q, cmd_err_nxt;
`endif

    // The word as it stands once the bit currently on MOSI is taken in.
    assign word = {rx_shift, bus.MOSI};

`ifdef SPI_CMD_CHECK_EN
    // Code bits must agree with the state that is receiving the word.
    always_comb begin
        word_ok = 1'b1;
        case (state)
            WRITE:     word_ok = ~word[W-1];
            READ_ADD:  word_ok = (word[W-1:W-2] == 2'b10);
            READ_DATA: word_ok = (word[W-1:W-2] == 2'b11);
            default:   word_ok = 1'b1;
        endcase
    end
`else
    assign word_ok = 1'b1;
`endif

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        state_nxt        = state;
        bit_cnt_nxt      = bit_cnt;
        rx_shift_nxt     = rx_shift;
        rx_data_nxt      = rx_data_q;
        rx_valid_nxt     = 1'b0;
        miso_nxt         = miso_q;
        rd_addr_flag_nxt = rd_addr_flag;
        word_done_nxt    = word_done;
        tx_wait_nxt      = tx_wait;
        tx_active_nxt    = tx_active;
        tx_shift_nxt     = tx_shift;
        tx_cnt_nxt       = tx_cnt;
`ifdef SPI_CMD_CHECK_EN
        cmd_err_nxt      = 1'b0;
`endif

        if ((state != IDLE) && bus.SS_n) begin
            // Frame aborted: drop any partial word, keep rd_addr_flag.
            state_nxt     = IDLE;
            bit_cnt_nxt   = '0;
            word_done_nxt = 1'b0;
            tx_wait_nxt   = 1'b0;
            tx_active_nxt = 1'b0;
            tx_cnt_nxt    = '0;
            miso_nxt      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.SS_n) begin
                        state_nxt = CHK_CMD;
                    end
                end

                CHK_CMD: begin
                    rx_shift_nxt = {{(W-2){1'b0}}, bus.MOSI};
                    bit_cnt_nxt  = CW'(ADDR_SIZE + 1);
                    if (!bus.MOSI) begin
                        state_nxt = WRITE;
                    end else if (rd_addr_flag) begin
                        state_nxt = READ_DATA;
                    end else begin
                        state_nxt = READ_ADD;
                    end
                end

                WRITE, READ_ADD, READ_DATA: begin
                    if (!word_done) begin
                        rx_shift_nxt = word[W-2:0];
                        bit_cnt_nxt  = bit_cnt - 1'b1;
                        if (bit_cnt == CW'(1)) begin
                            word_done_nxt = 1'b1;
                            if (word_ok) begin
                                rx_data_nxt  = word;
                                rx_valid_nxt = 1'b1;
                                if (state == READ_ADD) begin
                                    rd_addr_flag_nxt = 1'b1;
                                end
                                if (state == READ_DATA) begin
                                    rd_addr_flag_nxt = 1'b0;
                                    tx_wait_nxt      = 1'b1;
                                end
                            end
`ifdef SPI_CMD_CHECK_EN
                            else begin
                                cmd_err_nxt = 1'b1;
                            end
`endif
                        end
                    end else if (tx_wait) begin
                        // Only READ_DATA ever sets tx_wait; tx_valid is
                        // ignored everywhere else.
                        if (bus.tx_valid) begin
                            tx_wait_nxt   = 1'b0;
                            tx_active_nxt = 1'b1;
                            miso_nxt      = bus.tx_data[ADDR_SIZE-1];
                            tx_shift_nxt  = bus.tx_data[ADDR_SIZE-2:0];
                            tx_cnt_nxt    = TW'(ADDR_SIZE - 1);
                        end
                    end else if (tx_active) begin
                        if (tx_cnt != '0) begin
                            miso_nxt     = tx_shift[ADDR_SIZE-2];
                            tx_shift_nxt = {tx_shift[ADDR_SIZE-3:0], 1'b0};
                            tx_cnt_nxt   = tx_cnt - 1'b1;
                        end else begin
                            miso_nxt      = 1'b0;
                            tx_active_nxt = 1'b0;
                        end
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            miso_q       <= 1'b0;
            rd_addr_flag <= 1'b0;
            word_done    <= 1'b0;
            tx_wait      <= 1'b0;
            tx_active    <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
`ifdef SPI_CMD_CHECK_EN
            cmd_err_q    <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            rx_shift     <= rx_shift_nxt;
            rx_data_q    <= rx_data_nxt;
            rx_valid_q   <= rx_valid_nxt;
            miso_q       <= miso_nxt;
            rd_addr_flag <= rd_addr_flag_nxt;
            word_done    <= word_done_nxt;
            tx_wait      <= tx_wait_nxt;
            tx_active    <= tx_active_nxt;
            tx_shift     <= tx_shift_nxt;
            tx_cnt       <= tx_cnt_nxt;
`ifdef SPI_CMD_CHECK_EN
            cmd_err_q    <= cmd_err_nxt;
`endif
        end
    end

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
`ifdef SPI_CMD_CHECK_EN
    assign bus.cmd_err  = cmd_err_q;
`else
    assign bus.cmd_err  = 1'b0;
`endif

endmodule
